// File: rtl/multiplier_rr_scheduler.sv
// Round-robin front end that shares one sequential multiplier between NUM_REQ clients.
// Runs one job at a time: grant, start pulse, wait for done or watchdog abort, then hand back the result.
module multiplier_rr_scheduler #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_multiplicand,
    output logic [WIDTH-1:0]         mul_multiplier,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic                     resp_err,
    output logic                     busy
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [WD_W-1:0] watchdog;
    logic            found;
    logic [ID_W-1:0] gnt_idx;
    int              idx;

    // Scan starts just past the last winner, so the previous grantee has lowest priority.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

    assign req_ready  = (state == IDLE && found && !rst) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign mul_start  = (state == ISSUE);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= ID_W'(NUM_REQ - 1);
            watchdog         <= '0;
            resp_id          <= '0;
            resp_product     <= '0;
            resp_err         <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mul_multiplicand <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                        mul_multiplier   <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                        resp_id          <= gnt_idx;
                        rr_ptr           <= gnt_idx;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    watchdog <= watchdog + 1'b1;
                    // A done arriving on the final watchdog cycle still counts as success.
                    if (mul_done) begin
                        resp_product <= mul_product;
                        resp_err     <= 1'b0;
                        state        <= RESP;
                    end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
                        resp_product <= '0;
                        resp_err     <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
